// File: rtl/ddr_check_pkg.sv
// Shared constants, FSM encoding and fill/check pattern for the DDR readback path.
package ddr_check_pkg;

  localparam int unsigned AMM_ADDR_W  = 25;
  localparam int unsigned AMM_DATA_W  = 256;
  localparam int unsigned AMM_BURST_W = 7;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_COLLECT   = 3'd2;
  localparam logic [2:0] ST_CMP_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_ABORT     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_ISSUE     = ST_ISSUE,
    S_COLLECT   = ST_COLLECT,
    S_CMP_DRAIN = ST_CMP_DRAIN,
    S_DONE      = ST_DONE,
    S_ABORT     = ST_ABORT
  } state_e;

  // Lane i of word A is {7'b0, A} ^ (seed + i); the fill logic uses the same function.
  function automatic logic [AMM_DATA_W-1:0] pat_word(input logic [AMM_ADDR_W-1:0] addr,
                                                     input logic [31:0]            seed);
    logic [AMM_DATA_W-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < AMM_DATA_W / 32; i++) begin
      w[i*32 +: 32] = {7'b0, addr} ^ (seed + 32'(i));
    end
    return w;
  endfunction

endpackage

// File: rtl/ddr_beat_compare.sv
// Two-stage beat compare: register beat and expected word, then count
// mismatches (saturating) and capture the first failing address.
module ddr_beat_compare
  import ddr_check_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hA5A5_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  beat_vld_i,
  input  logic [AMM_DATA_W-1:0] beat_data_i,
  input  logic [AMM_ADDR_W-1:0] beat_addr_i,
  output logic [15:0]           err_count_o,
  output logic [AMM_ADDR_W-1:0] first_err_addr_o
);

  logic                  s1_vld_q;
  logic [AMM_DATA_W-1:0] s1_data_q;
  logic [AMM_DATA_W-1:0] s1_exp_q;
  logic [AMM_ADDR_W-1:0] s1_addr_q;

  logic [15:0]           err_q;
  logic [AMM_ADDR_W-1:0] first_q;
  logic                  seen_q;
  logic                  mism;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
      s1_exp_q  <= '0;
      s1_addr_q <= '0;
    end else begin
      s1_vld_q <= beat_vld_i && !clr_i;
      if (beat_vld_i) begin
        s1_data_q <= beat_data_i;
        s1_exp_q  <= pat_word(beat_addr_i, SEED);
        s1_addr_q <= beat_addr_i;
      end
    end
  end

  assign mism = s1_vld_q && (s1_data_q != s1_exp_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
    end else if (clr_i) begin
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
    end else if (mism) begin
      if (err_q != '1) begin
        err_q <= err_q + 16'd1;
      end
      if (!seen_q) begin
        first_q <= s1_addr_q;
        seen_q  <= 1'b1;
      end
    end
  end

  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;

endmodule

// File: rtl/ddr_readback_checker.sv
// Avalon-MM burst read master that verifies a DDR region against the
// address-derived fill pattern and reports pass/fail, errors and timeout.
module ddr_readback_checker
  import ddr_check_pkg::*;
#(
  parameter logic [AMM_ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int unsigned           NUM_WORDS      = 1024,
  parameter int unsigned           BURST_LEN      = 64,
  parameter logic [31:0]           SEED           = 32'hA5A5_0000,
  parameter int unsigned           TIMEOUT_CYCLES = 4096
) (
  input  logic                    avalon_clk,
  input  logic                    avalon_reset,
  input  logic                    start,
  input  logic                    setup_done,
  output logic [AMM_ADDR_W-1:0]   amm_addr,
  output logic                    amm_read,
  output logic [AMM_BURST_W-1:0]  amm_burstcount,
  output logic [31:0]             amm_byteenable,
  input  logic                    amm_ready,
  input  logic [AMM_DATA_W-1:0]   amm_readdata,
  input  logic                    amm_readdatavalid,
  output logic                    check_busy,
  output logic                    check_done,
  output logic                    check_pass,
  output logic [15:0]             err_count,
  output logic [AMM_ADDR_W-1:0]   first_err_addr,
  output logic                    timeout,
  output logic                    spurious_beat
);

  localparam int unsigned RW = AMM_ADDR_W + 1;
  localparam logic [RW-1:0]          NUM_R    = RW'(NUM_WORDS);
  localparam logic [RW-1:0]          BL_R     = RW'(BURST_LEN);
  localparam logic [AMM_BURST_W-1:0] BL_B     = AMM_BURST_W'(BURST_LEN);
  localparam logic [31:0]            TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [AMM_ADDR_W-1:0]  cur_addr_q, cur_addr_d;
  logic [RW-1:0]          remain_q, remain_d;
  logic [AMM_BURST_W-1:0] blen_q, blen_d;
  logic [AMM_BURST_W-1:0] beats_q, beats_d;
  logic [AMM_ADDR_W-1:0]  exp_addr_q, exp_addr_d;
  logic [31:0]            tmo_q, tmo_d;
  logic                   drain_q, drain_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic                   tmo_flag_q, tmo_flag_d;
  logic                   spur_q, spur_d;

  logic                   start_ok;
  logic                   tick;
  logic                   cmp_vld;
  logic [AMM_BURST_W-1:0] burst_sel;
  logic [15:0]            cmp_err;
  logic [AMM_ADDR_W-1:0]  cmp_first;

  assign burst_sel = (remain_q > BL_R) ? BL_B : remain_q[AMM_BURST_W-1:0];
  assign start_ok  = start && setup_done &&
                     (state_q == S_IDLE || state_q == S_DONE || state_q == S_ABORT);
  assign cmp_vld   = (state_q == S_COLLECT) && amm_readdatavalid;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    blen_d     = blen_q;
    beats_d    = beats_q;
    exp_addr_d = exp_addr_q;
    tmo_d      = tmo_q;
    drain_d    = drain_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    tmo_flag_d = tmo_flag_q;
    spur_d     = spur_q;
    tick       = 1'b0;

    if (amm_readdatavalid && state_q != S_COLLECT) begin
      spur_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ABORT: begin
        if (start_ok) begin
          cur_addr_d = BASE_ADDR;
          remain_d   = NUM_R;
          tmo_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          tmo_flag_d = 1'b0;
          spur_d     = 1'b0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (amm_ready) begin
          blen_d     = burst_sel;
          beats_d    = burst_sel;
          exp_addr_d = cur_addr_q;
          tmo_d      = '0;
          state_d    = S_COLLECT;
        end else begin
          tick = 1'b1;
        end
      end
      S_COLLECT: begin
        if (amm_readdatavalid) begin
          tmo_d      = '0;
          exp_addr_d = exp_addr_q + 1'b1;
          beats_d    = beats_q - 1'b1;
          if (beats_q == AMM_BURST_W'(1)) begin
            cur_addr_d = cur_addr_q + {{(AMM_ADDR_W-AMM_BURST_W){1'b0}}, blen_q};
            remain_d   = remain_q - {{(RW-AMM_BURST_W){1'b0}}, blen_q};
            drain_d    = 1'b0;
            state_d    = (remain_q == {{(RW-AMM_BURST_W){1'b0}}, blen_q}) ? S_CMP_DRAIN : S_ISSUE;
          end
        end else begin
          tick = 1'b1;
        end
      end
      S_CMP_DRAIN: begin
        // Second drain cycle: the last beat's compare result is already in cmp_err.
        if (drain_q) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (cmp_err == '0) && !tmo_flag_q;
          state_d = S_DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tick) begin
      if (tmo_q >= TMO_LAST) begin
        busy_d     = 1'b0;
        done_d     = 1'b1;
        pass_d     = 1'b0;
        tmo_flag_d = 1'b1;
        state_d    = S_ABORT;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end
  end

  always_ff @(posedge avalon_clk or posedge avalon_reset) begin
    if (avalon_reset) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      remain_q   <= '0;
      blen_q     <= '0;
      beats_q    <= '0;
      exp_addr_q <= '0;
      tmo_q      <= '0;
      drain_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tmo_flag_q <= 1'b0;
      spur_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      remain_q   <= remain_d;
      blen_q     <= blen_d;
      beats_q    <= beats_d;
      exp_addr_q <= exp_addr_d;
      tmo_q      <= tmo_d;
      drain_q    <= drain_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      tmo_flag_q <= tmo_flag_d;
      spur_q     <= spur_d;
    end
  end

  ddr_beat_compare #(
    .SEED(SEED)
  ) u_cmp (
    .clk_i            (avalon_clk),
    .rst_i            (avalon_reset),
    .clr_i            (start_ok),
    .beat_vld_i       (cmp_vld),
    .beat_data_i      (amm_readdata),
    .beat_addr_i      (exp_addr_q),
    .err_count_o      (cmp_err),
    .first_err_addr_o (cmp_first)
  );

  // Command fields are only meaningful while a read is requested; zero otherwise.
  assign amm_read       = (state_q == S_ISSUE);
  assign amm_addr       = amm_read ? cur_addr_q : '0;
  assign amm_burstcount = amm_read ? burst_sel : '0;
  assign amm_byteenable = '1;

  assign check_busy     = busy_q;
  assign check_done     = done_q;
  assign check_pass     = pass_q;
  assign err_count      = cmp_err;
  assign first_err_addr = cmp_first;
  assign timeout        = tmo_flag_q;
  assign spurious_beat  = spur_q;

endmodule
